// File: rtl/demux_bit_sequencer.sv
// demux_bit_sequencer: accepts a byte via in_valid/in_ready, then drives bit n on I with channel select S=n for HOLD_CYCLES en-qualified cycles each; busy marks a frame in progress and frame_done pulses once at its end
module demux_bit_sequencer #(
  parameter int HOLD_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       en,
  output logic       I,
  output logic [2:0] S,
  output logic       busy,
  output logic       frame_done
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam logic [3:0] LAST = 4'(HOLD_CYCLES - 1);
  state_t     state_q, state_d;
  logic [7:0] data_q, data_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] s_q, s_d;
  logic       i_q, i_d, rdy_q, rdy_d, busy_q, busy_d, fd_q, fd_d;
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    i_d     = i_q;
    rdy_d   = rdy_q;
    busy_d  = busy_q;
    fd_d    = fd_q;
    case (state_q)
      IDLE: if (in_valid && rdy_q) begin
        data_d  = in_data;
        s_d     = 3'd0;
        i_d     = in_data[0];
        cnt_d   = 4'd0;
        state_d = SHIFT;
        rdy_d   = 1'b0;
        busy_d  = 1'b1;
      end
      SHIFT: if (en) begin
        cnt_d = (cnt_q == LAST) ? 4'd0 : cnt_q + 4'd1;
        if (cnt_q == LAST && s_q == 3'd7) begin
          state_d = DONE;
          i_d     = 1'b0;
          fd_d    = 1'b1;
        end else if (cnt_q == LAST) begin
          s_d = s_q + 3'd1;
          i_d = data_q[s_q + 3'd1];
        end
      end
      default: begin
        state_d = IDLE;
        s_d     = 3'd0;
        i_d     = 1'b0;
        fd_d    = 1'b0;
        rdy_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= 8'd0;
      cnt_q   <= 4'd0;
      s_q     <= 3'd0;
      i_q     <= 1'b0;
      rdy_q   <= 1'b1;
      busy_q  <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      i_q     <= i_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
      fd_q    <= fd_d;
    end
  end
  assign in_ready   = rdy_q;
  assign I          = i_q;
  assign S          = s_q;
  assign busy       = busy_q;
  assign frame_done = fd_q;
endmodule

// File: tb/tb_demux_bit_sequencer.sv
// tb_demux_bit_sequencer: scoreboard bench driving three instances (HOLD_CYCLES 1, 3, 16) one at a time
module tb_demux_bit_sequencer;
  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] vld, en, rdy, busy, fd, i_o;
  logic [7:0] in_data;
  logic [2:0] s_o [3];
  typedef struct {int k; logic [2:0] s; logic i; logic fd;} exp_t;
  exp_t q[$];
  int cmp = 0, err = 0;
  always #5 clk = ~clk;
  demux_bit_sequencer #(.HOLD_CYCLES(1)) u0 (.clk(clk), .rst(rst), .in_valid(vld[0]), .in_ready(rdy[0]),
    .in_data(in_data), .en(en[0]), .I(i_o[0]), .S(s_o[0]), .busy(busy[0]), .frame_done(fd[0]));
  demux_bit_sequencer #(.HOLD_CYCLES(3)) u1 (.clk(clk), .rst(rst), .in_valid(vld[1]), .in_ready(rdy[1]),
    .in_data(in_data), .en(en[1]), .I(i_o[1]), .S(s_o[1]), .busy(busy[1]), .frame_done(fd[1]));
  demux_bit_sequencer #(.HOLD_CYCLES(16)) u2 (.clk(clk), .rst(rst), .in_valid(vld[2]), .in_ready(rdy[2]),
    .in_data(in_data), .en(en[2]), .I(i_o[2]), .S(s_o[2]), .busy(busy[2]), .frame_done(fd[2]));
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (busy[k]) begin
        cmp++;
        if (q.size() == 0) begin
          err++;
          $display("FAIL underflow: u%0d busy with S=%0d I=%0d fd=%0d but nothing expected", k, s_o[k], i_o[k], fd[k]);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (e.k != k || e.s != s_o[k] || e.i != i_o[k] || e.fd != fd[k]) begin
            err++;
            $display("FAIL frame u%0d: got S=%0d I=%0d fd=%0d expected u%0d S=%0d I=%0d fd=%0d",
                     k, s_o[k], i_o[k], fd[k], e.k, e.s, e.i, e.fd);
          end
        end
      end
    end
  end
  task automatic chk(input string n, input int a, input int e);
    cmp++;
    if (a != e) begin
      err++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask
  task automatic push_frame(input int k, input logic [7:0] d, input int h, input int sb, input int sn);
    for (int b = 0; b < 8; b++)
      for (int r = 0; r < h + ((b == sb) ? sn : 0); r++) q.push_back('{k, 3'(b), d[b], 1'b0});
    q.push_back('{k, 3'd7, 1'b0, 1'b1});
  endtask
  task automatic send(input int k, input logic [7:0] d, output int cyc);
    vld[k] = 1'b1;
    in_data = d;
    cyc = 0;
    while (!rdy[k] && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!rdy[k]) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    cyc++;
  endtask
  task automatic wait_ready(input int k, input int exp_n, input int n0);
    int n = n0;
    while (!rdy[k] && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    chk($sformatf("ready_latency_u%0d", k), n, exp_n);
  endtask
  initial begin
    int c;
    rst = 1'b1; vld = 3'b111; en = 3'b111; in_data = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_ready", rdy[k], 1); chk("rst_busy", busy[k], 0); chk("rst_I", i_o[k], 0);
      chk("rst_S", s_o[k], 0); chk("rst_fd", fd[k], 0);
    end
    rst = 1'b0; vld = 3'b000;
    @(posedge clk); #1;
    chk("post_rst_idle", busy, 0);
    send(0, 8'hA5, c);
    vld[0] = 1'b0;
    push_frame(0, 8'hA5, 1, -1, 0);
    wait_ready(0, 9, 0);
    send(1, 8'h0F, c);
    vld[1] = 1'b0;
    push_frame(1, 8'h0F, 3, 2, 2);
    repeat (6) @(posedge clk);
    #1 en[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1 en[1] = 1'b1;
    wait_ready(1, 27, 8);
    send(0, 8'h81, c);
    in_data = 8'h7E;
    push_frame(0, 8'h81, 1, -1, 0);
    send(0, 8'h7E, c);
    chk("b2b_gap", c, 10);
    vld[0] = 1'b0; in_data = 8'h00;
    push_frame(0, 8'h7E, 1, -1, 0);
    wait_ready(0, 9, 0);
    send(0, 8'h33, c);
    vld[0] = 1'b0;
    for (int b = 0; b < 5; b++) q.push_back('{0, 3'(b), c[0] & 1'b0 | ((8'h33 >> b) & 1) != 0, 1'b0});
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("abort_ready", rdy[0], 1); chk("abort_busy", busy[0], 0);
    chk("abort_S", s_o[0], 0); chk("abort_fd", fd[0], 0);
    send(0, 8'hFF, c);
    chk("first_after_rst", c, 1);
    vld[0] = 1'b0;
    push_frame(0, 8'hFF, 1, -1, 0);
    wait_ready(0, 9, 0);
    send(2, 8'h01, c);
    vld[2] = 1'b0;
    push_frame(2, 8'h01, 16, -1, 0);
    wait_ready(2, 129, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule

// File: doc/demux_bit_sequencer.md
DEMUX_BIT_SEQUENCER -- requirements
Module: demux_bit_sequencer

Interface
REQ-001 Parameter HOLD_CYCLES, default 1, number of en-qualified clock cycles each bit is presented; legal range 1..16.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  upstream byte offered.
REQ-005 in_ready  output  1  block can accept a byte this cycle.
REQ-006 in_data  input  8  byte to distribute; bit n goes to demux channel n.
REQ-007 en  input  1  advance enable; 0 freezes the SHIFT state.
REQ-008 I  output  1  data bit to the 1-to-8 demux input.
REQ-009 S  output  3  channel select to the 1-to-8 demux.
REQ-010 busy  output  1  high while a frame is being distributed (SHIFT or DONE).
REQ-011 frame_done  output  1  one-cycle pulse at end of each completed frame.

Function
REQ-012 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-013 FSM states SHALL be IDLE, SHIFT, DONE; encoding free.
REQ-014 IDLE: in_ready=1, busy=0, I=0, S=0, frame_done=0.
REQ-015 Handshake: transfer occurs on a rising edge where in_valid=1 and in_ready=1; in_valid while in_ready=0 SHALL be ignored; in_data SHALL be sampled only at transfer.
REQ-016 On transfer: store in_data, S<=0, I<=in_data[0], hold counter<=0, state<=SHIFT, in_ready<=0, busy<=1 (visible the cycle after the accepting edge).
REQ-017 SHIFT with en=1: hold counter increments; when it equals HOLD_CYCLES-1 the bit period ends.
REQ-018 End of bit period with S<7: S<=S+1, I<=stored bit S+1, hold counter<=0.
REQ-019 End of bit period with S=7: state<=DONE, I<=0, S held at 7, frame_done<=1.
REQ-020 SHIFT with en=0: I, S, hold counter, stored byte SHALL hold; en has no effect in IDLE or DONE.
REQ-021 DONE SHALL last exactly one cycle: frame_done=1, busy=1, in_ready=0; next state IDLE with S<=0, frame_done<=0, in_ready<=1, busy<=0.
REQ-022 With en held 1, each bit SHALL be presented for exactly HOLD_CYCLES cycles; in_ready SHALL return high 8*HOLD_CYCLES+1 cycles after the accepting edge.
REQ-023 Back-to-back: a byte offered during SHIFT/DONE SHALL be accepted on the first edge in IDLE if in_valid is still high; minimum gap between accepts is 8*HOLD_CYCLES+2 cycles.
REQ-024 S SHALL never wrap from 7 to 0 within a frame; exactly 8 channel periods per frame.
REQ-025 Hold counter SHALL be 4 bits wide; HOLD_CYCLES=16 uses full range without overflow.

Reset
REQ-026 rst=1 at a rising edge SHALL force IDLE and the REQ-014 output values, clear stored byte and hold counter, regardless of en or in_valid.
REQ-027 rst asserted mid-frame SHALL abort the frame with no frame_done pulse; a transfer coincident with rst SHALL be discarded.
REQ-028 First transfer possible on the first edge after rst deasserts.

Verification
REQ-029 Reset: rst high 2 cycles, in_valid=1 -> in_ready=1, busy=0, I=0, S=0, frame_done=0; no byte accepted.
REQ-030 HOLD_CYCLES=1, en=1, accept 8'hA5 -> (S,I) sequence 0/1,1/0,2/1,3/0,4/0,5/1,6/0,7/1, then frame_done=1 one cycle, in_ready=1 9 cycles after accept.
REQ-031 HOLD_CYCLES=3, accept 8'h0F, en low 2 cycles during S=2 -> S=2 held 5 cycles with I=1; frame completes 26 cycles after accept.
REQ-032 in_valid held high with 8'h81 then 8'h7E -> second byte accepted on first IDLE edge; 8'h7E never sampled mid-frame; two frame_done pulses.
REQ-033 rst pulsed at S=4 mid-frame -> IDLE next cycle, no frame_done, in_ready=1; new byte 8'hFF then sequences S=0..7 with I=1.
REQ-034 HOLD_CYCLES=16, accept 8'h01 -> S=0 held 16 cycles, I=1 only during S=0; frame_done 128 cycles after accept.
